// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, GPIO register map and
// default bus widths used by the APB master bridge and its neighbours.
package apb_pkg;

    localparam int APB_PDATA_SIZE = 32;
    localparam int APB_PADDR_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // GPIO slave register addresses
    localparam logic [3:0] GPIO_MODE      = 4'd0;
    localparam logic [3:0] GPIO_DIRECTION = 4'd1;
    localparam logic [3:0] GPIO_OUTPUT    = 4'd2;
    localparam logic [3:0] GPIO_INPUT     = 4'd3;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase watchdog for the APB master bridge. Counts ACCESS cycles
// with PREADY low and flags expiry on the cycle that would reach the limit.
module apb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic APB_CLK,
    input  logic APB_RESET_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    // Expiry fires on the TIMEOUT_CYCLES-th stalled cycle, so compare one below.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_reg;

    // Cleared in SETUP, counts every stalled ACCESS cycle.
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (waiting) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = waiting && (count_reg == LAST_COUNT);

endmodule

// File: rtl/apb_master_bridge.sv
// Command-stream to APB initiator. One transfer at a time:
// IDLE -> SETUP -> ACCESS -> RESP -> IDLE, single response beat per command.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int PDATA_SIZE     = APB_PDATA_SIZE,
    parameter int PADDR_SIZE     = APB_PADDR_SIZE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    APB_CLK,
    input  logic                    APB_RESET_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    APB_PSEL,
    output logic                    APB_PENABLE,
    output logic                    APB_PWRITE,
    output logic [PADDR_SIZE-1:0]   APB_PADDR,
    output logic [PDATA_SIZE/8-1:0] APB_PSTRB,
    output logic [PDATA_SIZE-1:0]   APB_PWDATA,
    input  logic [PDATA_SIZE-1:0]   APB_PRDATA,
    input  logic                    APB_PREADY,
    input  logic                    APB_PSLVERR
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]              state_reg, state_next;
    logic [PADDR_SIZE-1:0]   paddr_reg;
    logic                    pwrite_reg;
    logic [PDATA_SIZE-1:0]   pwdata_reg;
    logic [PDATA_SIZE/8-1:0] pstrb_reg;
    logic [PDATA_SIZE-1:0]   rdata_reg;
    logic                    err_reg;
    logic                    accept;
    logic                    done;
    logic                    expired;

    assign accept = (state_reg == ST_IDLE) && cmd_valid;
    assign done   = (state_reg == ST_ACCESS) && APB_PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic timeout_reg;

    apb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .APB_CLK     (APB_CLK),
        .APB_RESET_n (APB_RESET_n),
        .clear       (state_reg == ST_SETUP),
        .waiting     ((state_reg == ST_ACCESS) && !APB_PREADY),
        .expired     (expired)
    );

    // Timeout flag is part of the response; a normal completion clears it.
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            timeout_reg <= 1'b0;
        end else if (done) begin
            timeout_reg <= 1'b0;
        end else if (expired) begin
            timeout_reg <= 1'b1;
        end
    end

    assign rsp_timeout = timeout_reg;
`else
    // Without the watchdog ACCESS waits for PREADY indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Next-state decode; PREADY completion takes priority over expiry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (cmd_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (done || expired) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register; async reset drops the transfer immediately.
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command capture on accept and response capture at end of ACCESS.
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            pstrb_reg  <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                paddr_reg  <= cmd_addr;
                pwrite_reg <= cmd_write;
                pwdata_reg <= cmd_wdata;
                pstrb_reg  <= cmd_write ? cmd_strb : '0;
            end
            if (done) begin
                rdata_reg <= pwrite_reg ? '0 : APB_PRDATA;
                err_reg   <= APB_PSLVERR;
            end else if (expired) begin
                rdata_reg <= '0;
                err_reg   <= 1'b1;
            end
        end
    end

    // cmd_ready is gated by reset so it reads 0 while reset is held.
    assign cmd_ready   = (state_reg == ST_IDLE) && APB_RESET_n;
    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_rdata   = rdata_reg;
    assign rsp_err     = err_reg;
    assign APB_PSEL    = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign APB_PENABLE = (state_reg == ST_ACCESS);
    assign APB_PWRITE  = pwrite_reg;
    assign APB_PADDR   = paddr_reg;
    assign APB_PWDATA  = pwdata_reg;
    assign APB_PSTRB   = APB_PSEL ? pstrb_reg : '0;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge with a response scoreboard.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int TMO = 4;

    logic        APB_CLK = 1'b0;
    logic        APB_RESET_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        APB_PSEL, APB_PENABLE, APB_PWRITE;
    logic [3:0]  APB_PADDR;
    logic [3:0]  APB_PSTRB;
    logic [31:0] APB_PWDATA, APB_PRDATA;
    logic        APB_PREADY, APB_PSLVERR;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;
    rsp_t sb[$];

    always #5 APB_CLK = ~APB_CLK;

    apb_master_bridge #(
        .PDATA_SIZE     (32),
        .PADDR_SIZE     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .APB_CLK     (APB_CLK),
        .APB_RESET_n (APB_RESET_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .APB_PSEL    (APB_PSEL),
        .APB_PENABLE (APB_PENABLE),
        .APB_PWRITE  (APB_PWRITE),
        .APB_PADDR   (APB_PADDR),
        .APB_PSTRB   (APB_PSTRB),
        .APB_PWDATA  (APB_PWDATA),
        .APB_PRDATA  (APB_PRDATA),
        .APB_PREADY  (APB_PREADY),
        .APB_PSLVERR (APB_PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge APB_CLK);
        #1;
    endtask

    // One full command: drive, serve APB with wait states, check response.
    task automatic run_cmd(input string name, input logic wr, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int wait_n, input logic [31:0] prdata,
                           input logic err_wait, input logic err_final,
                           input int hold, input logic expect_tmo);
        rsp_t exp, got;
        int lat;
        int exp_lat;
        logic [3:0] exp_strb;
        exp.rdata = expect_tmo ? 32'h0 : (wr ? 32'h0 : prdata);
        exp.err   = expect_tmo ? 1'b1 : err_final;
        exp.tmo   = expect_tmo;
        exp_lat   = expect_tmo ? (2 + TMO) : (wait_n + 3);
        exp_strb  = wr ? strb : 4'h0;

        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        sb.push_back(exp);
        cycle();
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        cmd_addr  = 4'($urandom);
        cmd_strb  = 4'hF;

        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                check({name, "_setup_sel_en"}, {30'd0, APB_PSEL, APB_PENABLE}, 32'b10);
                check({name, "_setup_addr"}, 32'(APB_PADDR), 32'(addr));
                check({name, "_setup_write"}, 32'(APB_PWRITE), 32'(wr));
                check({name, "_setup_wdata"}, APB_PWDATA, wdata);
            end else begin
                check({name, "_access_sel_en"}, {30'd0, APB_PSEL, APB_PENABLE}, 32'b11);
                check({name, "_access_addr"}, 32'(APB_PADDR), 32'(addr));
            end
            check({name, "_pstrb"}, 32'(APB_PSTRB), 32'(exp_strb));
            APB_PREADY  = (k >= 2) && (k - 2 >= wait_n);
            APB_PSLVERR = APB_PREADY ? err_final : err_wait;
            APB_PRDATA  = APB_PREADY ? prdata : 32'hDEAD_BEEF;
            cycle();
        end
        APB_PREADY  = 1'b0;
        APB_PSLVERR = 1'b0;
        APB_PRDATA  = 32'h0;

        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({name, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({name, "_rdata"}, rsp_rdata, got.rdata);
            check({name, "_err"}, 32'(rsp_err), 32'(got.err));
            check({name, "_timeout"}, 32'(rsp_timeout), 32'(got.tmo));
        end
        check({name, "_resp_bus_idle"}, {30'd0, APB_PSEL, APB_PENABLE}, 32'b00);

        for (int h = 0; h < hold; h++) begin
            cycle();
            check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_hold_rdata"}, rsp_rdata, exp.rdata);
            check({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({name, "_hold_psel"}, 32'(APB_PSEL), 32'd0);
        end

        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_done_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_idle_pstrb"}, 32'(APB_PSTRB), 32'd0);
        check({name, "_idle_paddr_hold"}, 32'(APB_PADDR), 32'(addr));
        $display("TXN %s wr=%0d addr=%0d wdata=0x%08h rdata=0x%08h err=%0d tmo=%0d lat=%0d",
                 name, wr, addr, wdata, rsp_rdata, rsp_err, rsp_timeout, lat);
    endtask

    initial begin
        APB_RESET_n = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 4'h0;
        cmd_wdata   = 32'h0;
        cmd_strb    = 4'h0;
        rsp_ready   = 1'b0;
        APB_PRDATA  = 32'h0;
        APB_PREADY  = 1'b0;
        APB_PSLVERR = 1'b0;

        repeat (3) @(posedge APB_CLK);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_sel_en", {30'd0, APB_PSEL, APB_PENABLE}, 32'b00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", 32'(APB_PADDR), 32'd0);
        check("rst_pwdata", APB_PWDATA, 32'd0);
        check("rst_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);

        @(negedge APB_CLK);
        APB_RESET_n = 1'b1;
        cycle();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        //        name      wr    addr            wdata         strb  wait prdata         ew    ef    hold tmo
        run_cmd("wr_dir",   1'b1, GPIO_DIRECTION, 32'h0000_00FF, 4'hF, 0,   32'h0,         1'b0, 1'b0, 0,   1'b0);
        run_cmd("rd_in",    1'b0, GPIO_INPUT,     32'h1234_5678, 4'hF, 2,   32'h0000_0042, 1'b0, 1'b0, 0,   1'b0);
        run_cmd("wr_slverr",1'b1, GPIO_OUTPUT,    32'hCAFE_0001, 4'h3, 1,   32'h0,         1'b1, 1'b1, 0,   1'b0);
        run_cmd("rd_hold",  1'b0, GPIO_MODE,      32'h0,         4'hF, 3,   32'hA5A5_0001, 1'b1, 1'b0, 5,   1'b0);
        run_cmd("rd_term",  1'b0, GPIO_INPUT,     32'h0,         4'h0, TMO - 1, 32'h0000_0077, 1'b0, 1'b0, 0, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        run_cmd("rd_tmo",   1'b0, GPIO_INPUT,     32'h0,         4'h0, 1000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1,  1'b1);
`endif

        // Reset pulled during ACCESS: bus drops at once, no response.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = GPIO_OUTPUT;
        cmd_wdata = 32'h0000_0055;
        cmd_strb  = 4'hF;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        check("mid_access_penable", 32'(APB_PENABLE), 32'd1);
        #2;
        APB_RESET_n = 1'b0;
        #1;
        check("mid_rst_sel_en", {30'd0, APB_PSEL, APB_PENABLE}, 32'b00);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge APB_CLK);
        APB_RESET_n = 1'b1;
        #1;
        check("mid_rst_release_ready", 32'(cmd_ready), 32'd1);
        cycle();
        check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        $display("TXN reset_mid_access discarded");

        run_cmd("wr_after", 1'b1, GPIO_MODE,      32'h0F0F_F0F0, 4'h5, 1,   32'h0,         1'b0, 1'b0, 0,   1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the GPIO APB slave (and any other APB4 responder in the design). It serialises one transfer at a time, waits on PREADY, captures PRDATA/PSLVERR and returns a single response beat per command. It sits between the processor-side register bus and the peripheral APB segment.

## Interface
- PDATA_SIZE, 32, APB data width (multiple of 8)
- PADDR_SIZE, 4, APB address width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (timeout build only; range 1..255)

Ports:
- APB_CLK  in  1  clock
- APB_RESET_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  PADDR_SIZE  target address
- cmd_wdata  in  PDATA_SIZE  write data
- cmd_strb  in  PDATA_SIZE/8  byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  PDATA_SIZE  read data (0 for writes)
- rsp_err  out  1  PSLVERR sampled or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- APB_PSEL, APB_PENABLE, APB_PWRITE  out  1  APB control
- APB_PADDR  out  PADDR_SIZE
- APB_PSTRB  out  PDATA_SIZE/8
- APB_PWDATA  out  PDATA_SIZE
- APB_PRDATA  in  PDATA_SIZE
- APB_PREADY, APB_PSLVERR  in  1

## Operation
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: cmd_ready=1. On accept, register addr/write/wdata/strb (strb forced 0 on reads) onto APB_PADDR/PWRITE/PWDATA/PSTRB; go SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all address/data/control held stable. Edge with PREADY=1: capture rdata (PRDATA for reads, 0 for writes), rsp_err=PSLVERR, rsp_timeout=0; drop PSEL/PENABLE; go RESP. PSLVERR ignored while PREADY=0.
- RESP: rsp_valid=1, response fields stable; cmd_ready=0. On rsp_ready go IDLE.
- Idle APB outputs: PSEL=0, PENABLE=0; PADDR/PWDATA/PWRITE hold last transfer; PSTRB=0.
- Only one outstanding command; no pipelining across RESP.

## Timing
- Reset: all outputs 0 (cmd_ready=0 during reset, 1 on first cycle after release); state IDLE.
- Accept at edge N -> SETUP in cycle N+1 -> ACCESS from N+2 -> rsp_valid from edge after PREADY high (N+3 for zero-wait slave).
- Minimum 4 cycles per transfer with rsp_ready held high; next cmd_ready one cycle after rsp handshake.
- Each PREADY-low ACCESS cycle adds one cycle.
- Reset asserted mid-transfer: PSEL/PENABLE/rsp_valid drop asynchronously, command discarded, no response.
- rsp_valid held indefinitely until rsp_ready; APB bus idle meanwhile.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: 8-bit counter cleared on SETUP, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES with PREADY still 0, abort: PSEL/PENABLE drop next edge, RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. PREADY=1 on the terminal cycle completes normally.
- Not defined: ACCESS waits forever; rsp_timeout tied 0; TIMEOUT_CYCLES unused.

## Structure
- Shared package apb_pkg: FSM state enum (IDLE, SETUP, ACCESS, RESP), GPIO register address constants (MODE=0, DIRECTION=1, OUTPUT=2, INPUT=3), default PDATA_SIZE/PADDR_SIZE.
- One sub-module: apb_master_timeout (counter + expiry flag), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 1, wdata 0x0000_00FF, strb 4'hF, zero-wait slave -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr 3, slave PREADY low 2 cycles, PRDATA=0x0000_0042 -> rsp_valid at N+5, rsp_rdata=0x42, PSTRB=0 throughout.
- Write with PSLVERR=1 on ready cycle -> rsp_err=1, rsp_timeout=0; PSLVERR=1 while PREADY=0 ignored.
- rsp_ready low 5 cycles after response -> rsp_valid/rdata stable, cmd_ready=0, PSEL=0 for all 5 cycles.
- Timeout build, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Reset pulled in ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid; next command completes normally.
